// File: rtl/decoder_proj_pkg.sv
// Shared types, default widths and helpers for the decoder-sharing arbiter.
package decoder_proj_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned IN_W_DEF   = 7;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned SETTLE_DEF = 1;
  // Settle counter holds SETTLE-1, and SETTLE is at most 15
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    RESP        = 2'd2
  } state_e;

  // Requester-id width; a single requester still needs one bit
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/decoder_share_arb_if.sv
// Requester, decoder and response signals of the decoder-sharing arbiter.
interface decoder_share_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = 7,
  parameter int unsigned OUT_W = 8
);
  localparam int unsigned ID_W = decoder_proj_pkg::id_w(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_code;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      dec_in;
  logic [OUT_W-1:0]     dec_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_code, dec_out, rsp_ready,
    output req_ready, dec_in, rsp_valid, rsp_data, rsp_id, busy
  );

  // Requester / decoder / consumer side
  modport master (
    output req_valid, req_code, dec_out, rsp_ready,
    input  req_ready, dec_in, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] cand;

  // Walk indices ptr, ptr+1, ... mod NREQ and keep the first requester found
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/decoder_share_arb.sv
// Time-shares one combinational decoder among NREQ requesters, round-robin.
module decoder_share_arb
  import decoder_proj_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input logic                clock,
  input logic                reset_n,
  decoder_share_arb_if.slave bus
);

  localparam int unsigned ID_W = id_w(NREQ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [IN_W-1:0]  dec_in_q, dec_in_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [IN_W-1:0]  pick_code;
  logic [NREQ-1:0]  req_ready_c;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // One-hot mux of the granted requester's code
  always_comb begin
    pick_code = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_code = bus.req_code[i*IN_W +: IN_W];
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      dec_in_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      dec_in_q    <= dec_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state: grant in IDLE, count out the settle time, hold the response
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    dec_in_d    = dec_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        // reset_n gating keeps the accept pulse low while reset is asserted
        if (reset_n && pick_any) begin
          req_ready_c = pick_gnt;
          dec_in_d    = pick_code;
          id_d        = pick_idx;
          cnt_d       = CNT_W'(SETTLE - 1);
          state_d     = SETTLE_WAIT;
        end
      end
      SETTLE_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = bus.dec_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Served requester drops to lowest priority for the next grant
          ptr_d       = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.dec_in    = dec_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_share_arb.sv
// Scoreboard bench for decoder_share_arb: SETTLE=1 instance plus a SETTLE=3 instance.
module tb_decoder_share_arb;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_share_arb_if #(.NREQ(4), .IN_W(7), .OUT_W(8)) ifa ();
  decoder_share_arb_if #(.NREQ(4), .IN_W(7), .OUT_W(8)) ifb ();

  decoder_share_arb #(.NREQ(4), .IN_W(7), .OUT_W(8), .SETTLE(1)) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifa.slave)
  );

  decoder_share_arb #(.NREQ(4), .IN_W(7), .OUT_W(8), .SETTLE(3)) u_dut3 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifb.slave)
  );

  // Reference decoder
  function automatic logic [7:0] dec_f(input logic [6:0] c);
    return {^c, c ^ 7'h2A};
  endfunction

  // Instance A: decoder is purely combinational
  assign ifa.dec_out = dec_f(ifa.dec_in);

  // Instance B: decoder output follows its input two cycles late
  logic [6:0] b_d1 = '0;
  logic [6:0] b_d2 = '0;
  always @(posedge clk) begin
    b_d1 <= ifb.dec_in;
    b_d2 <= b_d1;
  end
  assign ifb.dec_out = dec_f(b_d2);

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t got_e;
  logic [6:0] code_a [4];
  logic [3:0] e_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"},  32'(ifa.req_ready), 32'd0);
    chk({tag, "_din"},  32'(ifa.dec_in),    32'd0);
    chk({tag, "_rv"},   32'(ifa.rsp_valid), 32'd0);
    chk({tag, "_rd"},   32'(ifa.rsp_data),  32'd0);
    chk({tag, "_rid"},  32'(ifa.rsp_id),    32'd0);
    chk({tag, "_busy"}, 32'(ifa.busy),      32'd0);
  endtask

  task automatic push_exp(input int unsigned k);
    exp_t e;
    e.id   = 2'(k);
    e.data = dec_f(code_a[k]);
    sb_q.push_back(e);
  endtask

  // Response monitor for instance A: pop on every handshake
  always begin
    @(negedge clk);
    #2;
    if (rst_n && ifa.rsp_valid && ifa.rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got_e = sb_q.pop_front();
        chk("rsp_id",   32'(ifa.rsp_id),   32'(got_e.id));
        chk("rsp_data", 32'(ifa.rsp_data), 32'(got_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    code_a[0] = 7'h23;
    code_a[1] = 7'h45;
    code_a[2] = 7'b1101100;
    code_a[3] = 7'h7E;
    rst_n         = 1'b0;
    ifa.req_valid = '0;
    ifa.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) ifa.req_code[i*7 +: 7] = code_a[i];
    ifb.req_valid = '0;
    ifb.rsp_ready = 1'b0;
    ifb.req_code  = '0;
    ifb.req_code[6:0] = 7'h5A;

    repeat (2) @(negedge clk);
    #1 chk_rst("rst");
    @(negedge clk); rst_n = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    ifa.req_valid = 4'b0100;
    ifa.rsp_ready = 1'b1;
    push_exp(2);
    #1;
    chk("t1_rdy",   32'(ifa.req_ready), 32'b0100);
    chk("t1_busy0", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    ifa.req_valid = '0;
    #1;
    chk("t1_rdy_lo", 32'(ifa.req_ready), 32'd0);
    chk("t1_dec_in", 32'(ifa.dec_in), 32'(code_a[2]));
    chk("t1_busy1",  32'(ifa.busy), 32'd1);
    chk("t1_rv_lo",  32'(ifa.rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_rv",  32'(ifa.rsp_valid), 32'd1);
    chk("t1_rid", 32'(ifa.rsp_id), 32'd2);
    @(negedge clk);
    #1;
    chk("t1_idle",     32'(ifa.busy), 32'd0);
    chk("t1_rv_done",  32'(ifa.rsp_valid), 32'd0);
    chk("t1_dec_hold", 32'(ifa.dec_in), 32'(code_a[2]));

    // Reset restores ptr=0; then all four requesters valid
    @(negedge clk); rst_n = 1'b0;
    #1 chk_rst("rst2");
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) ifa.req_valid = 4'hF;
      if (c == 13) ifa.req_valid = '0;
      if (c % 3 == 0) push_exp(32'((c / 3) % 4));
      e_rdy = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      #1 chk("t2_rdy", 32'(ifa.req_ready), 32'(e_rdy));
    end

    // Back-pressure on requester 1 (ptr is now 1)
    @(negedge clk);
    ifa.req_valid = 4'b0010;
    ifa.rsp_ready = 1'b0;
    push_exp(1);
    #1 chk("t3_rdy", 32'(ifa.req_ready), 32'b0010);
    @(negedge clk);
    #1 chk("t3_rdy_sw", 32'(ifa.req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("t3_rv_hold",  32'(ifa.rsp_valid), 32'd1);
      chk("t3_rid_hold", 32'(ifa.rsp_id), 32'd1);
      chk("t3_rd_hold",  32'(ifa.rsp_data), 32'(dec_f(code_a[1])));
      chk("t3_rdy_bp",   32'(ifa.req_ready), 32'd0);
    end
    @(negedge clk);
    ifa.rsp_ready = 1'b1;
    push_exp(1);
    #1 chk("t3_rdy_hs", 32'(ifa.req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_regrant", 32'(ifa.req_ready), 32'b0010);
    chk("t3_rv_lo",   32'(ifa.rsp_valid), 32'd0);
    @(negedge clk); ifa.req_valid = '0;
    @(negedge clk);

    // Wrap-around: grant 3, then 0 and 3 both valid must pick 0
    @(negedge clk);
    ifa.req_valid = 4'b1000;
    push_exp(3);
    #1 chk("t4_rdy3", 32'(ifa.req_ready), 32'b1000);
    @(negedge clk); ifa.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    ifa.req_valid = 4'b1001;
    push_exp(0);
    #1 chk("t4_wrap", 32'(ifa.req_ready), 32'b0001);
    @(negedge clk); ifa.req_valid = '0;
    @(negedge clk);

    // Reset during SETTLE_WAIT discards the in-flight request
    @(negedge clk);
    ifa.req_valid = 4'b0010;
    #1 chk("t5_rdy", 32'(ifa.req_ready), 32'b0010);
    @(negedge clk);
    ifa.req_valid = 4'b1000;
    rst_n = 1'b0;
    #1 chk_rst("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(3);
    #1 chk("t5_rdy3", 32'(ifa.req_ready), 32'b1000);
    @(negedge clk); ifa.req_valid = '0;
    @(negedge clk);

    // SETTLE=3 instance with a slow decoder
    @(negedge clk);
    ifb.req_valid = 4'b0001;
    ifb.rsp_ready = 1'b1;
    #1 chk("t6_rdy", 32'(ifb.req_ready), 32'b0001);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) ifb.req_valid = '0;
      #1 chk("t6_rv_lo", 32'(ifb.rsp_valid), 32'd0);
      if (c == 1) chk("t6_dec_in", 32'(ifb.dec_in), 32'h5A);
    end
    @(negedge clk);
    #1;
    chk("t6_rv",  32'(ifb.rsp_valid), 32'd1);
    chk("t6_rd",  32'(ifb.rsp_data), 32'(dec_f(7'h5A)));
    chk("t6_rid", 32'(ifb.rsp_id), 32'd0);
    @(negedge clk);
    #1;
    chk("t6_rv_done", 32'(ifb.rsp_valid), 32'd0);
    chk("t6_idle",    32'(ifb.busy), 32'd0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_share_arb.md
# decoder_share_arb

Round-robin arbiter and sequencer that time-shares one combinational decoder instance (7-bit code in, OUT_W-bit result out) among NREQ requesters. Each requester presents a code with a valid/ready handshake. The block grants one requester, drives the code into the shared decoder, and waits a programmable settle time. It then captures the decoder result and returns it, tagged with the requester id, on a single back-pressurable response channel. It sits between the requester logic and the decoder instance in the decoder project.

## Interface
- NREQ, 4: number of requesters (2..8)
- IN_W, 7: decoder input code width
- OUT_W, 8: decoder result width
- SETTLE, 1: cycles dec_in is held before sampling dec_out (1..15)
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_code  in  NREQ*IN_W  codes; requester i at bits [i*IN_W +: IN_W]
- req_ready  out  NREQ  one-hot accept pulse to the granted requester
- dec_in  out  IN_W  registered drive to the shared decoder
- dec_out  in  OUT_W  decoder result, combinational from dec_in
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  OUT_W  captured decoder result
- rsp_id  out  max(1,$clog2(NREQ))  index of the requester served
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SETTLE_WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - If any req_valid is high, grant the first valid index searching upward from ptr, wrapping modulo NREQ.
  - req_ready[g] is high combinationally in that cycle only. Handshake completes when req_valid[g] & req_ready[g].
  - On the clock edge: dec_in <= code[g], id <= g, cnt <= SETTLE-1, go to SETTLE_WAIT.
- **SETTLE_WAIT:**
  - req_ready is all zero; dec_in is held stable.
  - When cnt==0: rsp_data <= dec_out, rsp_valid <= 1, go to RESP. Otherwise cnt decrements.
- **RESP:**
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready is high.
  - On handshake: rsp_valid <= 0, ptr <= (id+1) mod NREQ, go to IDLE.
- Fairness: a requester that has been granted has lowest priority for the next grant. Any continuously valid requester is served within NREQ grants.
- req_valid may drop while in SETTLE_WAIT or RESP without effect; only the IDLE cycle matters.
- dec_in keeps its last code after the response is taken (no glitching back to 0).
- Reset asserted mid-operation:
  - FSM returns to IDLE; the in-flight response is discarded.
  - All outputs take their reset values.

## Timing
- Reset values: req_ready=0, dec_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. Internal ptr=0, cnt=0.
- Grant is seen at edge T, and dec_in is updated after T.
- rsp_valid rises after edge T+SETTLE, i.e. it is visible in cycle T+SETTLE+1.
- If rsp_ready is held high:
  - Response handshake occurs in cycle T+SETTLE+1.
  - IDLE is reached in cycle T+SETTLE+2, and the next grant happens in that same cycle.
  - Peak throughput is one request per SETTLE+2 cycles.
- rsp_data is sampled from dec_out exactly SETTLE cycles after dec_in changes.
- No combinational path from rsp_ready to req_ready. req_ready depends only on req_valid, ptr and state.

## Structure
- The shared package `decoder_proj_pkg` holds:
  - the state enum (IDLE/SETTLE_WAIT/RESP)
  - IN_W and OUT_W defaults
  - an id-width function
- One natural sub-module, `rr_pick`: combinational round-robin priority pick (req vector, ptr -> one-hot grant plus index).
- The counter and FSM stay in the top module.

## Test plan
- Single request: req_valid=4'b0100, code[2]=7'b1101100, SETTLE=1, rsp_ready=1.
  - req_ready=4'b0100 for one cycle.
  - dec_in=7'b1101100 next cycle.
  - rsp_valid with rsp_id=2, rsp_data=decoder(1101100) two cycles after the grant.
- All four requesters valid continuously, ptr=0 after reset:
  - Grant order is 0,1,2,3,0.
  - Each response id matches its grant.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_data and rsp_id remain stable.
  - No req_ready pulses occur.
  - After rsp_ready=1, the next grant follows one cycle after the handshake.
- SETTLE=3 with a decoder model whose output changes 2 cycles after its input:
  - rsp_data equals the settled value.
  - rsp_valid appears exactly 4 cycles after the grant.
- Reset mid-operation: assert reset_n=0 during SETTLE_WAIT.
  - All outputs go to their reset values immediately.
  - After release, a pending request from index 3 is granted with ptr=0 search order.
- Wrap-around: NREQ=4, last grant was 3, requesters 0 and 3 both valid -> grant 0.
